// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe_if
//  Purpose  : Bundle of the decode-side inputs and per-stage control outputs
//             of ctrl_pipe.
//  Ports    : master modport drives enable/op_code/in_valid/stall/flush/freeze
//             and observes ctrl_o/valid_o/illegal_o/illegal_cnt_o; the slave
//             modport (ctrl_pipe) is the mirror image.
//  Revision : 1.0 - initial release
// ============================================================================
interface ctrl_pipe_if #(
    parameter int ALU_OP_W  = 4,
    parameter int STAGES    = 3,
    parameter int ILL_CNT_W = 8
);
    localparam int c_cw = ALU_OP_W + 9;

    logic                      enable;
    logic [5:0]                op_code;
    logic                      in_valid;
    logic                      stall;
    logic                      flush;
    logic                      freeze;
    logic [STAGES*c_cw-1:0]    ctrl_o;
    logic [STAGES-1:0]         valid_o;
    logic                      illegal_o;
    logic [ILL_CNT_W-1:0]      illegal_cnt_o;

    modport master (
        output enable, op_code, in_valid, stall, flush, freeze,
        input  ctrl_o, valid_o, illegal_o, illegal_cnt_o
    );

    modport slave (
        input  enable, op_code, in_valid, stall, flush, freeze,
        output ctrl_o, valid_o, illegal_o, illegal_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe
//  Purpose  : Decodes the 6-bit ID opcode into a control word and carries it
//             through STAGES registered control stages (stage 0 = ID/EX).
//             Handles stall/flush bubbles, global freeze and illegal opcodes
//             (decoded as valid NOPs).
//  Ports    : clk, rst_n (async active-low), bus (ctrl_pipe_if.slave):
//             enable, op_code, in_valid, stall, flush, freeze in;
//             ctrl_o (stage k at [k*CW +: CW]), valid_o, illegal_o,
//             illegal_cnt_o out.
//  Config   : define CTRL_ILLEGAL_TRAP_EN to enable the illegal-opcode pulse
//             and saturating counter; otherwise both outputs are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int ALU_OP_W  = 4,
    parameter int STAGES    = 3,
    parameter int ILL_CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    ctrl_pipe_if.slave bus
);
    localparam int c_cw = ALU_OP_W + 9;

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic            w_reg_write;
    logic            w_mem_to_reg;
    logic            w_mem_write;
    logic            w_mem_read;
    logic            w_jump;
    logic            w_alu_src;
    logic            w_reg_dest;
    logic            w_is_beq;
    logic            w_branch;
    logic [3:0]      w_alu4;
    logic [c_cw-1:0] w_word;
    logic            w_capture;

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_jump       = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_dest   = 1'b0;
        w_is_beq     = 1'b0;
        w_branch     = 1'b0;
        w_alu4       = 4'b0000;
        casez (bus.op_code)
            6'b000000: begin                       // R-type
                w_reg_dest  = 1'b1;
                w_reg_write = 1'b1;
                w_alu4      = 4'b0000;
            end
            6'b000100: begin                       // BEQ
                w_branch = 1'b1;
                w_is_beq = 1'b1;
                w_alu4   = 4'b0001;
            end
            6'b000101: begin                       // BNE
                w_branch = 1'b1;
                w_alu4   = 4'b0011;
            end
            6'b000010: begin                       // J
                w_jump = 1'b1;
                w_alu4 = 4'b0100;
            end
            6'b000011: begin                       // JAL
                w_jump      = 1'b1;
                w_reg_dest  = 1'b1;
                w_reg_write = 1'b1;
                w_alu4      = 4'b0101;
            end
            6'b100???: begin                       // loads
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_alu4       = 4'b0110;
            end
            6'b101???: begin                       // stores
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_alu4      = 4'b0111;
            end
            6'b001???: begin                       // I-type ALU
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                case (bus.op_code[2:0])
                    3'b000:  w_alu4 = 4'b1000;
                    3'b001:  w_alu4 = 4'b1001;
                    3'b100:  w_alu4 = 4'b1010;
                    3'b101:  w_alu4 = 4'b1011;
                    3'b110:  w_alu4 = 4'b1100;
                    3'b111:  w_alu4 = 4'b1101;
                    3'b010:  w_alu4 = 4'b1110;
                    default: w_alu4 = 4'b1111;     // 3'b011
                endcase
            end
            default: ;                             // illegal -> all-zero NOP
        endcase
    end

    assign w_word = {ALU_OP_W'(w_alu4), w_branch, w_is_beq, w_reg_dest,
                     w_alu_src, w_jump, w_mem_read, w_mem_write,
                     w_mem_to_reg, w_reg_write};

    // A real instruction enters stage 0 only when nothing of higher priority
    // (freeze, flush, stall, decode disable, empty ID) applies.
    assign w_capture = !bus.freeze && !bus.flush && !bus.stall &&
                       bus.enable && bus.in_valid;

    // ------------------------------------------------------------------
    // Control stage chain
    // ------------------------------------------------------------------
    logic [c_cw-1:0]   r_ctrl [STAGES];
    logic [STAGES-1:0] r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctrl[k] <= '0;
            end
            r_valid <= '0;
        end else if (!bus.freeze) begin
            r_ctrl[0]  <= w_capture ? w_word : '0;
            r_valid[0] <= w_capture;
            for (int k = 1; k < STAGES; k++) begin
                r_ctrl[k]  <= r_ctrl[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_out
            assign bus.ctrl_o[k*c_cw +: c_cw] = r_ctrl[k];
            assign bus.valid_o[k]             = r_valid[k];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Illegal-opcode trap
    // ------------------------------------------------------------------
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                 r_illegal;
    logic [ILL_CNT_W-1:0] r_ill_cnt;
    logic                 w_ill_take;

    // Every legal opcode sets at least one control bit, so an all-zero
    // decoded word identifies an illegal opcode.
    assign w_ill_take = w_capture && (w_word == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_ill_cnt <= '0;
        end else if (bus.freeze) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_ill_take;
            if (w_ill_take && (r_ill_cnt != '1)) begin
                r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
            end
        end
    end

    assign bus.illegal_o     = r_illegal;
    assign bus.illegal_cnt_o = r_ill_cnt;
`else
    assign bus.illegal_o     = 1'b0;
    assign bus.illegal_cnt_o = '0;
`endif

endmodule
`default_nettype wire
